// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// Holds the op encoding, size codes, op classification helpers and the
// outstanding-queue entry record used by exe_lsu_issue and lsu_ot_queue.
package lsu_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_LWU = 4'd5,
    OP_LD  = 4'd6,
    OP_SB  = 4'd8,
    OP_SH  = 4'd9,
    OP_SW  = 4'd10,
    OP_SD  = 4'd11
  } lsu_op_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // nop: op that is undefined or unsupported at this data width; it is
  // answered with an empty response and never reaches the bus.
  typedef struct packed {
    lsu_op_e    op;
    logic [2:0] off;
    logic       ale;
    logic       nop;
    logic       issued;
    logic       done;
    logic       killed;
  } lsu_ent_t;

  function automatic logic is_load(lsu_op_e op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWU, OP_LD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(lsu_op_e op);
    case (op)
      OP_SB, OP_SH, OP_SW, OP_SD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed(lsu_op_e op);
    case (op)
      OP_LB, OP_LH, OP_LW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] op_size(lsu_op_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB:         return SZ_B;
      OP_LH, OP_LHU, OP_SH:         return SZ_H;
      OP_LW, OP_LWU, OP_SW:         return SZ_W;
      default:                      return SZ_D;
    endcase
  endfunction

  function automatic logic op_legal(lsu_op_e op, int unsigned data_w);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW: return 1'b1;
      OP_LWU, OP_LD, OP_SD: return (data_w == 64);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ot_queue.sv
// Outstanding-transaction queue for the LSU.
// Ports: push/push_ent/push_tag allocate at the tail (tail_idx exposes the
//   slot), full is decoded from the registered count; issue/issue_idx mark a
//   bus request accepted; data_ok/rdata complete the oldest issued, not-done
//   entry; flush kills every entry, reclaim returns the newest slot;
//   resp_valid/resp_ready and head_* present and pop the head entry.
module lsu_ot_queue
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TAG_W    = 5,
  parameter int unsigned OT_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        push,
  input  lsu_ent_t                    push_ent,
  input  logic [TAG_W-1:0]            push_tag,
  output logic [$clog2(OT_DEPTH)-1:0] tail_idx,
  output logic                        full,
  input  logic                        issue,
  input  logic [$clog2(OT_DEPTH)-1:0] issue_idx,
  input  logic                        data_ok,
  input  logic [DATA_W-1:0]           rdata,
  input  logic                        flush,
  input  logic                        reclaim,
  input  logic                        resp_ready,
  output logic                        resp_valid,
  output lsu_ent_t                    head_ent,
  output logic [TAG_W-1:0]            head_tag,
  output logic [DATA_W-1:0]           head_rdata
);

  localparam int unsigned PTR_W = $clog2(OT_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  lsu_ent_t          ents  [OT_DEPTH];
  logic [TAG_W-1:0]  tags  [OT_DEPTH];
  logic [DATA_W-1:0] datas [OT_DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             pop;
  logic             dok_hit;
  logic [PTR_W-1:0] dok_idx;
  logic [PTR_W-1:0] scan_idx;

  assign tail_idx   = tail;
  assign full       = (count == CNT_W'(OT_DEPTH));
  assign head_ent   = ents[head];
  assign head_tag   = tags[head];
  assign head_rdata = datas[head];

  // Killed entries leave silently once their bus transaction completes.
  assign resp_valid = (count != '0) && head_ent.done && !head_ent.killed;
  assign pop        = (count != '0) && head_ent.done && (head_ent.killed || resp_ready);

  // Requests issue in program order, so the first issued-but-not-done entry
  // walking from the head is the one the next data_ok belongs to.
  always_comb begin
    dok_hit  = 1'b0;
    dok_idx  = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < OT_DEPTH; i++) begin
      scan_idx = head + PTR_W'(i);
      if (!dok_hit && (CNT_W'(i) < count) && ents[scan_idx].issued && !ents[scan_idx].done) begin
        dok_hit = 1'b1;
        dok_idx = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < OT_DEPTH; i++) begin
        ents[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < OT_DEPTH; i++) begin
        if (flush)
          ents[i].killed <= 1'b1;
        if (issue && (issue_idx == PTR_W'(i)))
          ents[i].issued <= 1'b1;
        if (data_ok && dok_hit && (dok_idx == PTR_W'(i)))
          ents[i].done <= 1'b1;
      end
      if (push) begin
        ents[tail] <= push_ent;
        tail       <= tail + 1'b1;
      end else if (reclaim) begin
        tail <= tail - 1'b1;
      end
      if (pop)
        head <= head + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop) - CNT_W'(reclaim);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      tags[tail] <= push_tag;
    if (data_ok && dok_hit)
      datas[dok_idx] <= rdata;
  end

endmodule

// File: rtl/exe_lsu_issue.sv
// LSU issue stage: accepts load/store ops from EXE, drives one bus request
// per op, tracks outstanding ops in lsu_ot_queue and returns results in order.
// Ports: in_* op handshake from EXE; flush cancels everything in flight;
//   req/wr/size/wstrb/addr/wdata + addr_ok form the request channel;
//   data_ok/rdata complete requests in order; resp_* deliver head results.
module exe_lsu_issue
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned OT_DEPTH = 4,
  parameter int unsigned TAG_W    = 5
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_op,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic                flush,
  output logic                req,
  output logic                wr,
  output logic [1:0]          size,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic [TAG_W-1:0]    resp_tag,
  output logic                resp_is_load,
  output logic                resp_ale
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(LANES);
  localparam int unsigned PTR_W = $clog2(OT_DEPTH);
  localparam int unsigned IDX_W = $clog2(DATA_W);

  lsu_op_e           op_in;
  logic [1:0]        sz_in;
  logic              legal_in;
  logic              misalign_in;
  logic [2:0]        off_in;
  logic [7:0]        mask8;
  logic [LANES-1:0]  wstrb_in;
  logic [DATA_W-1:0] wdata_rep;
  lsu_ent_t          push_ent;
  logic              accept;
  logic              needs_req;

  logic              live;
  logic [PTR_W-1:0]  req_idx;
  logic [PTR_W-1:0]  tail_idx;
  logic              full;
  logic              issue;
  logic              reclaim;

  lsu_ent_t          head_ent;
  logic [DATA_W-1:0] head_rdata;
  logic [DATA_W-1:0] ld_shift;
  int unsigned       ld_bits;
  logic [IDX_W-1:0]  ld_msb;
  logic              ld_sign;
  logic              unused_bits;

  assign op_in     = lsu_op_e'(in_op);
  assign sz_in     = op_size(op_in);
  assign legal_in  = op_legal(op_in, DATA_W);
  assign needs_req = legal_in && !misalign_in;

  // A pending request may be replaced in the same cycle it is accepted, so
  // a new op is taken whenever the slot is free or being freed by addr_ok.
  assign in_ready = live && !full && (!req || addr_ok) && !flush;
  assign accept   = in_valid && in_ready;
  assign issue    = req && addr_ok;
  // The pending request always belongs to the newest entry: no op can be
  // accepted behind it until addr_ok frees the request slot.
  assign reclaim  = flush && req && !addr_ok;

  always_comb begin
    off_in = '0;
    off_in[OFF_W-1:0] = in_addr[OFF_W-1:0];
    case (sz_in)
      SZ_B:    misalign_in = 1'b0;
      SZ_H:    misalign_in = in_addr[0];
      SZ_W:    misalign_in = |in_addr[1:0];
      default: misalign_in = |in_addr[2:0];
    endcase
    case (sz_in)
      SZ_B:    mask8 = 8'h01;
      SZ_H:    mask8 = 8'h03;
      SZ_W:    mask8 = 8'h0F;
      default: mask8 = 8'hFF;
    endcase
    wstrb_in = LANES'(mask8) << off_in[OFF_W-1:0];
    case (sz_in)
      SZ_B:    wdata_rep = {LANES{in_wdata[7:0]}};
      SZ_H:    wdata_rep = {(LANES/2){in_wdata[15:0]}};
      SZ_W:    wdata_rep = {(LANES/4){in_wdata[31:0]}};
      default: wdata_rep = in_wdata;
    endcase
  end

  always_comb begin
    push_ent        = '0;
    push_ent.op     = op_in;
    push_ent.off    = off_in;
    push_ent.ale    = legal_in && misalign_in;
    push_ent.nop    = !legal_in;
    push_ent.done   = !needs_req;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      live    <= 1'b0;
      req     <= 1'b0;
      wr      <= 1'b0;
      size    <= '0;
      wstrb   <= '0;
      addr    <= '0;
      wdata   <= '0;
      req_idx <= '0;
    end else begin
      live <= 1'b1;
      if (accept && needs_req) begin
        req     <= 1'b1;
        wr      <= is_store(op_in);
        size    <= sz_in;
        wstrb   <= is_store(op_in) ? wstrb_in : '0;
        addr    <= in_addr;
        wdata   <= wdata_rep;
        req_idx <= tail_idx;
      end else if (req && (addr_ok || flush)) begin
        req   <= 1'b0;
        wr    <= 1'b0;
        wstrb <= '0;
      end
    end
  end

  lsu_ot_queue #(
    .DATA_W  (DATA_W),
    .TAG_W   (TAG_W),
    .OT_DEPTH(OT_DEPTH)
  ) u_queue (
    .clk       (clk),
    .resetn    (resetn),
    .push      (accept),
    .push_ent  (push_ent),
    .push_tag  (in_tag),
    .tail_idx  (tail_idx),
    .full      (full),
    .issue     (issue),
    .issue_idx (req_idx),
    .data_ok   (data_ok),
    .rdata     (rdata),
    .flush     (flush),
    .reclaim   (reclaim),
    .resp_ready(resp_ready),
    .resp_valid(resp_valid),
    .head_ent  (head_ent),
    .head_tag  (resp_tag),
    .head_rdata(head_rdata)
  );

  assign resp_is_load = is_load(head_ent.op);
  assign resp_ale     = head_ent.ale;
  assign unused_bits  = ^{head_ent.issued, head_ent.done, head_ent.killed, head_ent.off};

  always_comb begin
    ld_shift = head_rdata >> {head_ent.off[OFF_W-1:0], 3'b000};
    ld_bits  = 32'd8 << op_size(head_ent.op);
    if (ld_bits > DATA_W)
      ld_bits = DATA_W;
    ld_msb   = IDX_W'(ld_bits - 1);
    ld_sign  = is_signed(head_ent.op) && ld_shift[ld_msb];
    resp_data = '0;
    if (is_load(head_ent.op) && !head_ent.ale && !head_ent.nop) begin
      for (int unsigned b = 0; b < DATA_W; b++) begin
        resp_data[b] = (b < ld_bits) ? ld_shift[b] : ld_sign;
      end
    end
  end

endmodule

// File: tb/tb_exe_lsu_issue.sv
module tb_exe_lsu_issue;
  import lsu_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int OT_DEPTH = 4;
  localparam int TAG_W = 5;

  logic clk, resetn;
  logic in_valid, in_ready;
  logic [3:0] in_op;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic [TAG_W-1:0] in_tag;
  logic flush;
  logic req, wr;
  logic [1:0] size;
  logic [DATA_W/8-1:0] wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic addr_ok, data_ok;
  logic [DATA_W-1:0] rdata;
  logic resp_valid, resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic resp_is_load, resp_ale;

  exe_lsu_issue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OT_DEPTH(OT_DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata), .in_tag(in_tag),
    .flush(flush), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag), .resp_is_load(resp_is_load),
    .resp_ale(resp_ale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int resp_seen = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              is_load;
    logic              ale;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Response scoreboard: every head handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (resetn && resp_valid && resp_ready) begin
      resp_seen++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got tag %0d data 0x%0h expected no response", resp_tag, resp_data);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_tag", resp_tag, mon_e.tag);
        chk("resp_data", resp_data, mon_e.data);
        chk("resp_is_load", resp_is_load, mon_e.is_load);
        chk("resp_ale", resp_ale, mon_e.ale);
      end
    end
  end

  // Request stability while waiting for addr_ok.
  logic        hold_chk = 1'b0;
  logic [38:0] hold_f;
  logic [31:0] hold_d;
  always @(negedge clk) begin
    if (hold_chk && resetn) begin
      chk("req_hold", req, 1'b1);
      chk("req_fields_hold", {wr, size, wstrb, addr}, hold_f);
      chk("req_wdata_hold", wdata, hold_d);
    end
    hold_chk = resetn && req && !addr_ok && !flush;
    hold_f   = {wr, size, wstrb, addr};
    hold_d   = wdata;
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        has_req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] resp;
    logic        is_load;
    logic        ale;
  } vec_t;
  localparam int NV = 15;
  vec_t vt [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 for 40 cycles expected 1");
    end
    tick();
  endtask

  task automatic offer(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_addr  = a;
    in_wdata = wd;
    in_tag   = tag;
    wait_accept();
    in_valid = 1'b0;
  endtask

  task automatic bus_cycle(input logic [31:0] rd);
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;
    data_ok = 1'b1;
    rdata   = rd;
    tick();
    data_ok = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk("drain_left", sb.size(), 0);
    sb.delete();
  endtask

  int cnt;
  int t0;
  int seen0;

  initial begin
    vt[0]  = '{OP_LW,  32'h1004, 32'h0,        32'h80FF00AA, 1'b1, 1'b0, 2'd2, 4'h0, 32'h0,        32'h80FF00AA, 1'b1, 1'b0};
    vt[1]  = '{OP_LB,  32'h1003, 32'h0,        32'h80FF00AA, 1'b1, 1'b0, 2'd0, 4'h0, 32'h0,        32'hFFFFFF80, 1'b1, 1'b0};
    vt[2]  = '{OP_LBU, 32'h1003, 32'h0,        32'h80FF00AA, 1'b1, 1'b0, 2'd0, 4'h0, 32'h0,        32'h00000080, 1'b1, 1'b0};
    vt[3]  = '{OP_LH,  32'h1002, 32'h0,        32'h80FF00AA, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0,        32'hFFFF80FF, 1'b1, 1'b0};
    vt[4]  = '{OP_LHU, 32'h1000, 32'h0,        32'h80FF00AA, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0,        32'h000000AA, 1'b1, 1'b0};
    vt[5]  = '{OP_LB,  32'h1000, 32'h0,        32'h80FF00AA, 1'b1, 1'b0, 2'd0, 4'h0, 32'h0,        32'hFFFFFFAA, 1'b1, 1'b0};
    vt[6]  = '{OP_LHU, 32'h1002, 32'h0,        32'h80FF00AA, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0,        32'h000080FF, 1'b1, 1'b0};
    vt[7]  = '{OP_SH,  32'h2002, 32'h1234,     32'hFFFFFFFF, 1'b1, 1'b1, 2'd1, 4'hC, 32'h12341234, 32'h0,        1'b0, 1'b0};
    vt[8]  = '{OP_SB,  32'h2001, 32'h5A,       32'hFFFFFFFF, 1'b1, 1'b1, 2'd0, 4'h2, 32'h5A5A5A5A, 32'h0,        1'b0, 1'b0};
    vt[9]  = '{OP_SW,  32'h2000, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1, 1'b1, 2'd2, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    vt[10] = '{OP_LW,  32'h3001, 32'h0,        32'h0,        1'b0, 1'b0, 2'd2, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1};
    vt[11] = '{OP_SH,  32'h3003, 32'h77,       32'h0,        1'b0, 1'b0, 2'd1, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1};
    vt[12] = '{OP_LD,  32'h4000, 32'h0,        32'h0,        1'b0, 1'b0, 2'd3, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0};
    vt[13] = '{OP_LWU, 32'h4000, 32'h0,        32'h0,        1'b0, 1'b0, 2'd2, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0};
    vt[14] = '{OP_SD,  32'h4000, 32'h0,        32'h0,        1'b0, 1'b0, 2'd3, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0};

    resetn = 1'b0; in_valid = 1'b0; in_op = '0; in_addr = '0; in_wdata = '0;
    in_tag = '0; flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
    resp_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req", req, 1'b0);
    chk("rst_wr", wr, 1'b0);
    chk("rst_wstrb", wstrb, 4'h0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    tick();
    resetn = 1'b1;

    // Table of single ops.
    for (int i = 0; i < NV; i++) begin
      sb.push_back('{TAG_W'(i), vt[i].resp, vt[i].is_load, vt[i].ale});
      offer(vt[i].op, vt[i].a, vt[i].wd, TAG_W'(i));
      @(negedge clk);
      chk($sformatf("v%0d_req", i), req, vt[i].has_req);
      if (vt[i].has_req) begin
        chk($sformatf("v%0d_wr", i), wr, vt[i].wr);
        chk($sformatf("v%0d_size", i), size, vt[i].size);
        chk($sformatf("v%0d_wstrb", i), wstrb, vt[i].wstrb);
        chk($sformatf("v%0d_addr", i), addr, vt[i].a);
        if (vt[i].wr) chk($sformatf("v%0d_wdata", i), wdata, vt[i].exp_wdata);
        tick();
        bus_cycle(vt[i].rd);
      end
      drain();
    end

    // addr_ok delayed by two cycles: request held three cycles.
    sb.push_back('{5'd20, 32'h80FF00AA, 1'b1, 1'b0});
    offer(OP_LW, 32'h1004, 32'h0, 5'd20);
    cnt = 0;
    @(negedge clk); if (req) cnt++; tick();
    @(negedge clk); if (req) cnt++; tick(); addr_ok = 1'b1;
    @(negedge clk); if (req) cnt++; tick(); addr_ok = 1'b0;
    @(negedge clk);
    chk("lw_req_cycles", cnt, 3);
    chk("lw_req_after_addr_ok", req, 1'b0);
    tick();
    data_ok = 1'b1; rdata = 32'h80FF00AA; tick(); data_ok = 1'b0;
    drain();

    // Misaligned op followed by an aligned one.
    sb.push_back('{5'd21, 32'h0, 1'b1, 1'b1});
    sb.push_back('{5'd22, 32'h13579BDF, 1'b1, 1'b0});
    offer(OP_LW, 32'h3001, 32'h0, 5'd21);
    offer(OP_LW, 32'h3000, 32'h0, 5'd22);
    @(negedge clk);
    chk("after_ale_req", req, 1'b1);
    chk("after_ale_addr", addr, 32'h3000);
    tick();
    bus_cycle(32'h13579BDF);
    drain();

    // Full throughput until the queue fills, then in-order completion.
    addr_ok = 1'b1;
    t0 = cyc;
    for (int i = 0; i < OT_DEPTH; i++) begin
      sb.push_back('{TAG_W'(24 + i), 32'h11110000 + i, 1'b1, 1'b0});
      in_valid = 1'b1; in_op = OP_LW; in_addr = 32'h5000 + 4 * i;
      in_tag = TAG_W'(24 + i);
      wait_accept();
    end
    in_valid = 1'b0;
    chk("fill_cycles", cyc - t0, OT_DEPTH);
    @(negedge clk);
    chk("full_in_ready", in_ready, 1'b0);
    tick();
    addr_ok = 1'b0;
    @(negedge clk);
    chk("full_req_done", req, 1'b0);
    chk("full_in_ready2", in_ready, 1'b0);
    tick();
    for (int i = 0; i < OT_DEPTH; i++) begin
      data_ok = 1'b1; rdata = 32'h11110000 + i; tick();
    end
    data_ok = 1'b0;
    drain();

    // Flush with two issued loads and a third pending.
    addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = OP_LW; in_addr = 32'h6100 + 4 * i;
      in_tag = TAG_W'(28 + i);
      wait_accept();
    end
    in_valid = 1'b0;
    addr_ok  = 1'b0;
    @(negedge clk);
    chk("pre_flush_req", req, 1'b1);
    seen0 = resp_seen;
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    @(negedge clk);
    chk("flush_req_drop", req, 1'b0);
    tick();
    data_ok = 1'b1; rdata = 32'hBAD0BAD0; tick(); tick(); data_ok = 1'b0;
    repeat (4) tick();
    chk("flush_no_resp", resp_seen - seen0, 0);
    @(negedge clk);
    chk("flush_in_ready", in_ready, 1'b1);
    tick();
    sb.push_back('{5'd31, 32'hCAFEF00D, 1'b1, 1'b0});
    offer(OP_LW, 32'h6000, 32'h0, 5'd31);
    bus_cycle(32'hCAFEF00D);
    drain();

    // Reset with a request outstanding.
    offer(OP_LW, 32'h7000, 32'h0, 5'd3);
    addr_ok = 1'b1; tick(); addr_ok = 1'b0;
    resetn = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_req", req, 1'b0);
    chk("mid_rst_resp_valid", resp_valid, 1'b0);
    tick();
    resetn = 1'b1;
    sb.push_back('{5'd9, 32'h0000FFFF, 1'b1, 1'b0});
    offer(OP_LHU, 32'h7006, 32'h0, 5'd9);
    bus_cycle(32'hFFFF1234);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exe_lsu_issue.md
EXE_LSU_ISSUE -- requirements
Module: exe_lsu_issue

Interface
REQ-001 Parameter ADDR_W, 32, address width.
REQ-002 Parameter DATA_W, 32, data width; legal values 32 or 64.
REQ-003 Parameter OT_DEPTH, 4, outstanding-queue entries; power of 2, at least 2.
REQ-004 Parameter TAG_W, 5, destination-register tag width.
REQ-005 Reset is resetn, synchronous, active-low; clock is clk.
REQ-006 Ports:
- clk in 1: clock
- resetn in 1: reset
- in_valid in 1: op offered by EXE
- in_ready out 1: op accepted
- in_op in 4: lsu_pkg op code
- in_addr in ADDR_W: effective address
- in_wdata in DATA_W: store source, low-aligned
- in_tag in TAG_W: destination register
- flush in 1: wb exception/cancel
- req out 1: bus request
- wr out 1: store
- size out 2: 0=B, 1=H, 2=W, 3=D
- wstrb out DATA_W/8: byte enables
- addr out ADDR_W: request address
- wdata out DATA_W: lane-replicated store data
- addr_ok in 1: request accepted
- data_ok in 1: oldest accepted request done
- rdata in DATA_W: load data
- resp_valid out 1: head entry result available
- resp_ready in 1: MEM stage takes result
- resp_data out DATA_W: extended load data
- resp_tag out TAG_W: destination register
- resp_is_load out 1: entry is a load
- resp_ale out 1: misaligned-address exception

Function
REQ-007 Ops: LB, LBU, LH, LHU, LW, LWU, LD, SB, SH, SW, SD; LWU, LD and SD are illegal when DATA_W=32 and SHALL be treated as a no-op response (resp_ale=0, resp_data=0).
REQ-008 in_ready SHALL equal !queue_full && (!req || addr_ok) && !flush.
REQ-009 A handshake (in_valid && in_ready) SHALL allocate the queue tail entry {op, tag, byte offset, ale, issued=0, done=0, killed=0}.
REQ-010 ale SHALL be set for an H op with addr[0]!=0, a W op with addr[1:0]!=0, or a D op with addr[2:0]!=0; an ale entry is born done and SHALL never raise req.
REQ-011 A non-ale op SHALL raise req on the cycle after acceptance with addr/size/wr/wstrb/wdata registered; these SHALL hold stable until addr_ok.
REQ-012 addr_ok && req SHALL set issued on that entry; back-to-back acceptance in the same cycle is allowed, giving one request per cycle at full throughput.
REQ-013 wstrb SHALL select size bytes at the addr offset within DATA_W/8 lanes; wdata SHALL replicate the B/H/W source across all lanes; loads SHALL drive wstrb=0 and wr=0.
REQ-014 data_ok SHALL mark the oldest issued, not-done entry done and capture rdata; data_ok with no issued entry SHALL be ignored.
REQ-015 resp_valid SHALL be asserted when the head entry is done and not killed; resp_data SHALL be the shifted, sign- or zero-extended load value, and 0 for stores and ale entries.
REQ-016 The head SHALL pop on resp_valid && resp_ready, or silently when it is done and killed; at most one pop per cycle.
REQ-017 Simultaneous push and pop with the queue full SHALL NOT be allowed, because in_ready uses the registered full flag; pointers SHALL wrap modulo OT_DEPTH.
REQ-018 On flush:
- all entries SHALL be marked killed
- a pending, non-issued request SHALL be dropped, req=0 next cycle, and its tail slot reclaimed
- if addr_ok coincides with flush, the request counts as issued and its data_ok SHALL be awaited and discarded
REQ-019 Killed issued entries SHALL still consume data_ok in order; resp_valid SHALL stay 0 until all killed entries drain.

Reset
REQ-020 Under resetn=0, the following SHALL be 0 next edge:
- req, wr, wstrb, resp_valid, in_ready
- pointers, count, and all entry flags
REQ-021 Reset mid-transaction SHALL abandon the outstanding request without waiting for data_ok.

Structure
REQ-022 Package lsu_pkg SHALL hold the op enum, size codes, the is_load/is_store/is_signed helpers, and the entry struct.
REQ-023 One sub-module, lsu_ot_queue, SHALL hold the parametrised OT_DEPTH entry array, pointers, and the issued/done search.

Verification
REQ-024 LW addr 0x1004 accepted, addr_ok after 2 cycles, data_ok with rdata 0x80FF00AA -> req held 3 cycles stable; resp_data=0x80FF00AA.
REQ-025 LB addr 0x1003, rdata 0x80FF00AA -> resp_data=0xFFFFFF80; LBU -> 0x00000080.
REQ-026 SH addr 0x2002, wdata 0x1234 -> wstrb=1100, wdata=0x12341234, size=1; resp_is_load=0 after data_ok.
REQ-027 LW addr 0x3001 -> no req, resp_ale=1 on next cycle; following LW to 0x3000 still issues.
REQ-028 OT_DEPTH=4, addr_ok every cycle, data_ok withheld -> 4 issued then in_ready=0; then 4 data_ok -> 4 in-order responses.
REQ-029 2 issued loads, flush with a third pending and addr_ok=0 -> req drops, 2 data_ok swallowed, no resp_valid; next op responds normally.
